// File: rtl/avalon_multi_interval_timer_if.sv
// avalon_multi_interval_timer_if: Avalon-MM slave bus bundle for the interval timer
//   address/chipselect/write_n/writedata come from the master, readdata returns from the slave
interface avalon_multi_interval_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_multi_interval_timer.sv
// avalon_multi_interval_timer: NUM_CH down-counting interval timers sharing one prescaler
//   clk, reset_n       : system clock, asynchronous active-low reset
//   bus (slave)        : Avalon-MM word-addressed register access, 1-cycle registered readdata
//   irq                : OR over channels of sticky timeout & interrupt enable
//   timeout_pulse      : one-cycle pulse per channel, one clock after its counter reaches 0
module avalon_multi_interval_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 16,
    parameter int RESET_PERIOD = 50000 - 1,
    parameter int ADDR_W       = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    avalon_multi_interval_timer_if.slave bus,
    output logic                         irq,
    output logic [NUM_CH-1:0]            timeout_pulse
);
    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
    localparam int PRE_A = 4 * NUM_CH;

    logic             wr;
    logic [31:0]      a;
    logic [PRE_W-1:0] pre_q, pre_d, prescale_q, prescale_d;
    logic             tick, we_pre;
    logic [31:0]      rd_q, rd_d;
    logic [31:0]      st_v [NUM_CH];
    logic [31:0]      ct_v [NUM_CH];
    logic [31:0]      pe_v [NUM_CH];
    logic [31:0]      sn_v [NUM_CH];
    logic [NUM_CH-1:0] pend;

    assign wr = bus.chipselect & ~bus.write_n;
    assign a  = 32'(bus.address);

    // Shared prescaler: tick on the cycle pre_cnt equals PRESCALE; a PRESCALE write restarts the count.
    assign we_pre     = wr && a == 32'(PRE_A);
    assign tick       = pre_q == prescale_q;
    assign pre_d      = (we_pre || tick) ? '0 : pre_q + PRE_W'(1);
    assign prescale_d = we_pre ? bus.writedata[PRE_W-1:0] : prescale_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
        logic ito_q, ito_d, cont_q, cont_d, run_q, run_d, to_q, to_d;
        logic zero_q, force_q, force_d, pulse_q;
        logic we_st, we_ct, we_pe, we_sn, start, stop, at_zero, ev;
        assign we_st   = wr && a == 32'(4 * n);
        assign we_ct   = wr && a == 32'(4 * n + 1);
        assign we_pe   = wr && a == 32'(4 * n + 2);
        assign we_sn   = wr && a == 32'(4 * n + 3);
        assign start   = we_ct & bus.writedata[2];
        assign stop    = we_ct & bus.writedata[3];
        assign at_zero = cnt_q == '0;
        // Edge-detect on reaching zero so a counter parked at 0 fires only once.
        assign ev      = at_zero & ~zero_q;
        // A PERIOD write reloads and stops the channel one edge later, without waiting for a tick.
        assign cnt_d    = force_q ? period_q
                        : (run_q && tick) ? (at_zero ? period_q : cnt_q - CNT_W'(1)) : cnt_q;
        assign run_d    = start ? 1'b1 : (stop || force_q || (at_zero && !cont_q && tick)) ? 1'b0 : run_q;
        assign to_d     = we_st ? 1'b0 : ev ? 1'b1 : to_q;
        assign period_d = we_pe ? bus.writedata[CNT_W-1:0] : period_q;
        assign snap_d   = we_sn ? cnt_q : snap_q;
        assign ito_d    = we_ct ? bus.writedata[0] : ito_q;
        assign cont_d   = we_ct ? bus.writedata[1] : cont_q;
        assign force_d  = we_pe;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= RST_P;
                period_q <= RST_P;
                snap_q   <= '0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                run_q    <= 1'b0;
                to_q     <= 1'b0;
                zero_q   <= 1'b0;
                force_q  <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                period_q <= period_d;
                snap_q   <= snap_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                run_q    <= run_d;
                to_q     <= to_d;
                zero_q   <= at_zero;
                force_q  <= force_d;
                pulse_q  <= ev;
            end
        end
        assign st_v[n]          = {30'd0, run_q, to_q};
        assign ct_v[n]          = {30'd0, cont_q, ito_q};
        assign pe_v[n]          = 32'(period_q);
        assign sn_v[n]          = 32'(snap_q);
        assign pend[n]          = to_q & ito_q;
        assign timeout_pulse[n] = pulse_q;
    end

    // Readback is unconditional on chipselect; unmapped addresses fall through to 0.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_d = (a == 32'(4 * i))     ? st_v[i] : rd_d;
            rd_d = (a == 32'(4 * i + 1)) ? ct_v[i] : rd_d;
            rd_d = (a == 32'(4 * i + 2)) ? pe_v[i] : rd_d;
            rd_d = (a == 32'(4 * i + 3)) ? sn_v[i] : rd_d;
        end
        rd_d = (a == 32'(PRE_A)) ? 32'(prescale_q) : (a == 32'(PRE_A + 1)) ? 32'(pend) : rd_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q      <= '0;
            prescale_q <= '0;
            rd_q       <= '0;
        end else begin
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.readdata = rd_q;
    assign irq          = |pend;
endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// tb_avalon_multi_interval_timer: directed plus randomized bus traffic checked against a register-level model
module tb_avalon_multi_interval_timer;
    localparam int NCH = 4;
    localparam int RP  = 49999;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           irq;
    logic [NCH-1:0] timeout_pulse;
    int compared = 0, mismatched = 0;

    avalon_multi_interval_timer_if #(.ADDR_W(5)) bus ();

    avalon_multi_interval_timer #(
        .NUM_CH(NCH), .CNT_W(32), .PRE_W(16), .RESET_PERIOD(RP), .ADDR_W(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave), .irq(irq), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: the programmer-visible registers plus counter state, advanced one edge at a time.
    logic [31:0] m_cnt [NCH], m_per [NCH], m_snap [NCH];
    bit          m_ito [NCH], m_cont [NCH], m_run [NCH], m_to [NCH];
    bit          m_zero [NCH], m_force [NCH], m_pulse [NCH];
    logic [31:0] m_pre, m_presc, m_rd;
    int          pcnt [NCH];

    function automatic void model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n] = RP; m_per[n] = RP; m_snap[n] = 0;
            m_ito[n] = 0; m_cont[n] = 0; m_run[n] = 0; m_to[n] = 0;
            m_zero[n] = 0; m_force[n] = 0; m_pulse[n] = 0;
        end
        m_pre = 0; m_presc = 0; m_rd = 0;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p = 0;
        for (int n = 0; n < NCH; n++) p[n] = m_to[n] & m_ito[n];
        return p;
    endfunction

    function automatic logic [31:0] model_read(int ad);
        if (ad < 4 * NCH) begin
            case (ad % 4)
                0: return {30'd0, m_run[ad / 4], m_to[ad / 4]};
                1: return {30'd0, m_cont[ad / 4], m_ito[ad / 4]};
                2: return m_per[ad / 4];
                default: return m_snap[ad / 4];
            endcase
        end
        if (ad == 4 * NCH) return m_presc;
        if (ad == 4 * NCH + 1) return model_pend();
        return 0;
    endfunction

    function automatic void model_step(bit w, int ad, logic [31:0] d);
        bit tick = (m_pre == m_presc);
        m_rd = model_read(ad);
        for (int n = 0; n < NCH; n++) begin
            bit ctl    = w && ad == 4 * n + 1;
            bit start  = ctl && d[2];
            bit stop   = ctl && d[3];
            bit zero   = (m_cnt[n] == 0);
            bit ev     = zero && !m_zero[n];
            logic [31:0] c = m_cnt[n];
            if (m_force[n]) m_cnt[n] = m_per[n];
            else if (m_run[n] && tick) m_cnt[n] = zero ? m_per[n] : c - 1;
            if (start) m_run[n] = 1;
            else if (stop || m_force[n] || (zero && !m_cont[n] && tick)) m_run[n] = 0;
            if (w && ad == 4 * n) m_to[n] = 0;
            else if (ev) m_to[n] = 1;
            m_zero[n]  = zero;
            m_pulse[n] = ev;
            if (w && ad == 4 * n + 3) m_snap[n] = c;
            m_force[n] = w && ad == 4 * n + 2;
            if (m_force[n]) m_per[n] = d;
            if (ctl) begin m_ito[n] = d[0]; m_cont[n] = d[1]; end
        end
        m_pre = ((w && ad == 4 * NCH) || tick) ? 0 : m_pre + 1;
        if (w && ad == 4 * NCH) m_presc = {16'd0, d[15:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        logic [31:0] pm = 0;
        for (int n = 0; n < NCH; n++) pm[n] = m_pulse[n];
        chk("readdata", bus.readdata, m_rd);
        chk("irq", 32'(irq), 32'(model_pend() != 0));
        chk("timeout_pulse", 32'(timeout_pulse), pm);
    endtask

    task automatic cyc(bit cs, bit wn, int ad, logic [31:0] wd);
        bus.chipselect = cs; bus.write_n = wn; bus.address = 5'(ad); bus.writedata = wd;
        @(posedge clk);
        model_step(cs && !wn, ad, wd);
        #1;
        chk_outputs();
        for (int n = 0; n < NCH; n++) pcnt[n] += int'(timeout_pulse[n]);
    endtask

    task automatic wr_reg(int ad, logic [31:0] d); cyc(1'b1, 1'b0, ad, d); endtask
    task automatic rd_reg(int ad); cyc(1'b0, 1'b1, ad, 32'd0); endtask
    task automatic idle(int k); repeat (k) cyc(1'b0, 1'b1, 0, 32'd0); endtask

    initial begin
        int first, second, found;
        bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
        model_reset();
        for (int n = 0; n < NCH; n++) pcnt[n] = 0;
        #2;
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pulse", 32'(timeout_pulse), 0);
        #10 reset_n = 1;

        // 1: reset values
        rd_reg(2);
        chk("t1_period", bus.readdata, RP);
        rd_reg(0);
        chk("t1_status", bus.readdata, 0);
        idle(5);
        chk("t1_pulses", 32'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 0);

        // 2: ch0 continuous, period 9, every-cycle tick
        wr_reg(2, 9);
        wr_reg(1, 7);
        first = -1; second = -1;
        for (int i = 0; i < 60 && second < 0; i++) begin
            idle(1);
            if (timeout_pulse[0]) begin
                if (first < 0) first = i; else second = i;
            end
        end
        chk("t2_interval", 32'(second - first), 10);
        chk("t2_irq_set", 32'(irq), 1);
        wr_reg(0, 0);
        chk("t2_irq_clr", 32'(irq), 0);
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            idle(1);
            found = int'(timeout_pulse[0]);
        end
        chk("t2_irq_rerise", 32'(irq), 1);

        // 3: ch1 one-shot, period 3, prescale 4
        wr_reg(6, 3);
        wr_reg(16, 4);
        pcnt[1] = 0;
        wr_reg(5, 5);
        idle(80);
        chk("t3_pulses", 32'(pcnt[1]), 1);
        rd_reg(4);
        chk("t3_status", bus.readdata, 1);
        wr_reg(7, 0);
        rd_reg(7);
        chk("t3_snap", bus.readdata, 3);

        // 4: PERIOD write mid-count reloads and stops
        wr_reg(10, 50);
        wr_reg(9, 4);
        idle(12);
        wr_reg(10, 100);
        idle(1);
        rd_reg(8);
        chk("t4_run", bus.readdata, 0);
        wr_reg(11, 0);
        rd_reg(11);
        chk("t4_snap", bus.readdata, 100);

        // 5: STATUS clear coinciding with a timeout event
        wr_reg(16, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (m_cnt[0] == 0 && !m_zero[0]) found = 1;
            else idle(1);
        end
        chk("t5_found", 32'(found), 1);
        wr_reg(0, 0);
        rd_reg(0);
        chk("t5_status", bus.readdata, 2);
        wr_reg(13, 12);
        rd_reg(12);
        chk("t5_start_wins", bus.readdata, 2);

        // 6: all channels continuous, then reset mid-run
        for (int n = 0; n < NCH; n++) wr_reg(4 * n + 2, 5 + n);
        for (int n = 0; n < NCH; n++) wr_reg(4 * n + 1, 7);
        idle(40);
        rd_reg(17);
        chk("t6_pend", bus.readdata, 32'hF);
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("t6_rst_irq", 32'(irq), 0);
        chk("t6_rst_pulse", 32'(timeout_pulse), 0);
        chk("t6_rst_readdata", bus.readdata, 0);
        @(posedge clk);
        #3 reset_n = 1;
        for (int n = 0; n < NCH; n++) pcnt[n] = 0;
        idle(40);
        chk("t6_no_pulses", 32'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 0);
        for (int n = 0; n < NCH; n++) begin
            rd_reg(4 * n + 2);
            chk("t6_period_rst", bus.readdata, RP);
        end
        rd_reg(17);
        chk("t6_pend_rst", bus.readdata, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int op = int'($urandom_range(0, 99));
            int ad;
            logic [31:0] d;
            if (op < 55) begin
                cyc(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 31)), $urandom);
            end else begin
                ad = int'($urandom_range(0, 19));
                d  = $urandom;
                if (ad < 16 && ad % 4 == 2) d = $urandom_range(0, 12);
                if (ad == 16) d = $urandom_range(0, 3);
                cyc(1'(op < 95), 1'b0, ad, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
